// File: rtl/chaos_disp_pkg.sv
// Shared types, default VGA timing and mu sweep constants for the chaos-map display.
// Imported by chaos_scan_ctrl and mu_sweep.
package chaos_disp_pkg;

    typedef logic [17:0] mu_t;
    typedef logic [9:0]  coord_t;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam mu_t DEF_MU_START        = 18'h2_8000;
    localparam mu_t DEF_MU_END          = 18'h3_FFFF;
    localparam mu_t DEF_MU_STEP         = 18'h0_0100;
    localparam int  DEF_FRAMES_PER_STEP = 4;

    // One sweep step; the carry bit of the 19-bit sum catches 18-bit overflow.
    function automatic mu_t mu_next(input mu_t cur, input mu_t step,
                                    input mu_t mu_end, input mu_t mu_start);
        logic [18:0] sum;
        sum = {1'b0, cur} + {1'b0, step};
        return (sum > {1'b0, mu_end}) ? mu_start : sum[17:0];
    endfunction

endpackage

// File: rtl/chaos_scan_ctrl_mu_sweep.sv
// Frame counter and mu step/wrap logic; only instantiated when CHAOS_MU_SWEEP_EN is defined.
// Steps mu on the restart strobe once FRAMES_PER_STEP frames have elapsed and pause is low.
module mu_sweep
    import chaos_disp_pkg::*;
#(
    parameter mu_t MU_START        = DEF_MU_START,
    parameter mu_t MU_END          = DEF_MU_END,
    parameter mu_t MU_STEP         = DEF_MU_STEP,
    parameter int  FRAMES_PER_STEP = DEF_FRAMES_PER_STEP
) (
    input  logic CLK,
    input  logic RST,
    input  logic pause,
    input  logic frame_start,
    input  logic step_slot,
    output mu_t  mu
);

    localparam logic [7:0] FRAME_LIMIT = 8'(FRAMES_PER_STEP);

    logic [7:0] frame_cnt;

    // step_slot is high on the edge that drops cyc_rst_n, so the new mu
    // appears together with the restart strobe.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            frame_cnt <= '0;
            mu        <= MU_START;
        end else if (step_slot) begin
            if (frame_cnt == FRAME_LIMIT && !pause) begin
                frame_cnt <= '0;
                mu        <= mu_next(mu, MU_STEP, MU_END, MU_START);
            end
        end else if (frame_start && frame_cnt != FRAME_LIMIT) begin
            frame_cnt <= frame_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/chaos_scan_ctrl.sv
// Raster scan controller: row/col counters, registered sync/DE/blanked colour, engine restart
// strobe and mu sweep. Define CHAOS_MU_SWEEP_EN to compile in the animated mu sweep.
module chaos_scan_ctrl
    import chaos_disp_pkg::*;
#(
    parameter int  H_ACTIVE        = DEF_H_ACTIVE,
    parameter int  H_FP            = DEF_H_FP,
    parameter int  H_SYNC          = DEF_H_SYNC,
    parameter int  H_BP            = DEF_H_BP,
    parameter int  V_ACTIVE        = DEF_V_ACTIVE,
    parameter int  V_FP            = DEF_V_FP,
    parameter int  V_SYNC          = DEF_V_SYNC,
    parameter int  V_BP            = DEF_V_BP,
    parameter mu_t MU_START        = DEF_MU_START,
    parameter mu_t MU_END          = DEF_MU_END,
    parameter mu_t MU_STEP         = DEF_MU_STEP,
    parameter int  FRAMES_PER_STEP = DEF_FRAMES_PER_STEP
) (
    input  logic   CLK,
    input  logic   RST,
    input  logic   pause,
    input  logic   red_in,
    input  logic   green_in,
    input  logic   blue_in,
    output coord_t row,
    output coord_t col,
    output mu_t    mu,
    output logic   cyc_rst_n,
    output logic   hsync,
    output logic   vsync,
    output logic   de,
    output logic   red,
    output logic   green,
    output logic   blue,
    output logic   frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam coord_t H_LAST     = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST     = coord_t'(V_TOTAL - 1);
    localparam coord_t HS_BEGIN   = coord_t'(H_ACTIVE + H_FP);
    localparam coord_t HS_END     = coord_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam coord_t VS_BEGIN   = coord_t'(V_ACTIVE + V_FP);
    localparam coord_t VS_END     = coord_t'(V_ACTIVE + V_FP + V_SYNC);
    localparam coord_t H_ACT_LIM  = coord_t'(H_ACTIVE);
    localparam coord_t V_ACT_LIM  = coord_t'(V_ACTIVE);

    coord_t col_nxt;
    coord_t row_nxt;
    logic   active_raw;
    logic   hsync_raw;
    logic   vsync_raw;
    logic   step_slot;
    logic   frame_slot;

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        col_nxt = col + 10'd1;
        row_nxt = row;
        if (col == H_LAST) begin
            col_nxt = '0;
            row_nxt = (row == V_LAST) ? '0 : row + 10'd1;
        end
    end

    assign active_raw = (col < H_ACT_LIM) && (row < V_ACT_LIM);
    assign hsync_raw  = !((col >= HS_BEGIN) && (col < HS_END));
    assign vsync_raw  = !((row >= VS_BEGIN) && (row < VS_END));

    // Decoded on the next position so the registered strobes line up with the counters.
    assign step_slot  = (row_nxt == V_ACT_LIM) && (col_nxt == '0);
    assign frame_slot = (row_nxt == '0) && (col_nxt == '0);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            row         <= '0;
            col         <= '0;
            cyc_rst_n   <= 1'b0;
            frame_start <= 1'b0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            de          <= 1'b0;
            red         <= 1'b0;
            green       <= 1'b0;
            blue        <= 1'b0;
        end else begin
            row         <= row_nxt;
            col         <= col_nxt;
            cyc_rst_n   <= !step_slot;
            frame_start <= frame_slot;
            hsync       <= hsync_raw;
            vsync       <= vsync_raw;
            de          <= active_raw;
            // Colour is sampled with the same decode that feeds de, keeping blanking aligned.
            red         <= active_raw & red_in;
            green       <= active_raw & green_in;
            blue        <= active_raw & blue_in;
        end
    end

`ifdef CHAOS_MU_SWEEP_EN
    mu_sweep #(
        .MU_START        (MU_START),
        .MU_END          (MU_END),
        .MU_STEP         (MU_STEP),
        .FRAMES_PER_STEP (FRAMES_PER_STEP)
    ) u_mu_sweep (
        .CLK         (CLK),
        .RST         (RST),
        .pause       (pause),
        .frame_start (frame_start),
        .step_slot   (step_slot),
        .mu          (mu)
    );
`else
    logic unused_pause;
    assign unused_pause = pause;
    assign mu           = MU_START;
`endif

endmodule
